lpddr2_bridge: RTL and testbench
================================

# lpddr2_bridge

Single-clock bridge between the CPU memory stage's LPDDR2 request port (`address`, `write_data`, `read_req`, `write_req`, `read_data`) and the Avalon-MM local interface of the LPDDR2 hard controller. It turns level-held CPU requests into exactly one single-beat Avalon transaction each. It absorbs `waitrequest` back-pressure and `readdatavalid` latency, and returns a held read word plus busy/done status. It sits between `memory_master` and the controller IP, clocked by `mem_clk`.

## Interface
- `ADDR_W`, 27: word address width on both sides.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 1023: max cycles waiting for `avl_readdatavalid` or `avl_waitrequest` deassertion.
- `ERR_WORD`, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- `clk`  in  1  memory clock (`mem_clk`); all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `address`  in  ADDR_W  CPU word address.
- `write_data`  in  DATA_W  CPU store data.
- `read_req`  in  1  CPU read request, level, held across many `clk` cycles.
- `write_req`  in  1  CPU write request, level.
- `read_data`  out  DATA_W  last completed read word, held.
- `busy`  out  1  transaction in flight.
- `done`  out  1  one-cycle pulse on completion.
- `err`  out  1  sticky timeout/conflict flag; cleared only by `rst`.
- `avl_ready`  in  1  controller calibration done.
- `avl_address`  out  ADDR_W  controller address.
- `avl_read`, `avl_write`  out  1  command strobes.
- `avl_writedata`  out  DATA_W  store data.
- `avl_byteenable`  out  DATA_W/8  always all ones.
- `avl_burstcount`  out  3  constant 1.
- `avl_waitrequest`  in  1  controller stall.
- `avl_readdata`  in  DATA_W  read data.
- `avl_readdatavalid`  in  1  read data strobe.

## Operation
- FSM states: `INIT` → `IDLE` → {`RD_CMD` → `RD_WAIT`, `WR_CMD`} → `IDLE`.
- `INIT`: wait for `avl_ready`=1, then go to `IDLE`. Requests arriving during `INIT` are latched as pending and served on entry to `IDLE`.
- Request acceptance is edge-triggered: a request is accepted on the rising edge of `read_req` or `write_req`, registered against the previous-cycle value. A held level never re-issues.
- In `IDLE`, on acceptance: capture `address` and `write_data` into command registers.
  - Write edge → `WR_CMD`.
  - Read edge → `RD_CMD`.
  - Both edges in the same cycle: write wins, `err` is set, the read is dropped.
- `RD_CMD`: `avl_read`=1 with the captured address. When `avl_waitrequest`=0, go to `RD_WAIT`.
- `RD_WAIT`: on `avl_readdatavalid`, set `read_data`←`avl_readdata`, pulse `done`, go to `IDLE`.
- `WR_CMD`: `avl_write`=1. When `avl_waitrequest`=0, pulse `done` and go to `IDLE`.
- Timeout counter:
  - Resets on every state entry and increments in `RD_CMD`, `RD_WAIT` and `WR_CMD`.
  - When it reaches `TIMEOUT`: drop the strobe, set `err`, pulse `done`, go to `IDLE`.
  - A read that times out sets `read_data`←`ERR_WORD`.
  - A late `readdatavalid` arriving in `IDLE` is ignored.
- New request edges while `busy`=1 are ignored, with no queueing.
- `busy`=1 in every state except `IDLE` and `INIT`.

## Timing
- Reset values: state=`INIT`; `read_data`=0; `busy`=0; `done`=0; `err`=0; `avl_read`=0; `avl_write`=0; `avl_address`=0; `avl_writedata`=0; `avl_byteenable`=all ones; `avl_burstcount`=1.
- A request edge sampled at cycle N puts the strobe on the Avalon bus from cycle N+1.
- The strobe and address stay stable while `avl_waitrequest`=1. The strobe is deasserted the cycle after `waitrequest` is sampled low.
- Read latency, with no stalls and readdatavalid latency L: `done` and the new `read_data` are visible at N+2+L.
- Write latency, with no stalls: `done` at N+2.
- `done` is high for exactly one cycle. `read_data` changes only on the same cycle `done` rises.
- `rst` mid-transaction: all outputs return to reset values on the next edge. Any in-flight controller response is discarded.
- The CPU clock is divided from `mem_clk` (≥2:1). The CPU must hold its request at least until `done`.

## Structure
- Shared package `mem_pkg`:
  - `bridge_state_t` enum.
  - `ERR_WORD`.
  - LPDDR2 address width constant.
- One sub-module is natural: `req_edge_detect`, a per-request registered rising-edge detector used for both `read_req` and `write_req`.
- The FSM, timeout counter and output registers stay in `lpddr2_bridge`.

## Test plan
- Reset, then `avl_ready`=0 for 20 cycles with `read_req` held → no `avl_read` until `avl_ready` rises; exactly one read issued afterwards; `read_data` updated once.
- Read addr 0x0000010, `waitrequest` high 3 cycles, readdatavalid latency 4, readdata 0x12345678 → `avl_read` held 4 cycles, `done` pulse, `read_data`=0x12345678.
- Write addr 0x7FFFFFF, data 0xA5A5A5A5, `waitrequest` never high → one-cycle `avl_write` with that address and data; `done` at N+2; `read_data` unchanged.
- `read_req` and `write_req` rising together → only `avl_write` issued; `err`=1 and stays 1 until reset.
- Read with `readdatavalid` never asserted → `done` after `TIMEOUT` cycles; `read_data`=0xDEADBEEF; `err`=1; a late `readdatavalid` is ignored.
- `rst` asserted while in `RD_WAIT` → next cycle `busy`=0, `avl_read`=0, state `INIT`; a following read completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-stage definitions: LPDDR2 widths, bridge FSM states and the
// read word returned when the controller never answers.
package mem_pkg;

    localparam int          LPDDR2_ADDR_W = 27;
    localparam int          LPDDR2_DATA_W = 32;
    localparam logic [31:0] ERR_WORD      = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD_CMD,
        RD_WAIT,
        WR_CMD
    } bridge_state_t;

endpackage

// File: rtl/lpddr2_bridge_if.sv
// Avalon-MM local interface of the LPDDR2 hard controller, bridge side is master.
interface lpddr2_bridge_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 32
);
    logic                  avl_ready;
    logic [ADDR_W-1:0]     avl_address;
    logic                  avl_read;
    logic                  avl_write;
    logic [DATA_W-1:0]     avl_writedata;
    logic [DATA_W/8-1:0]   avl_byteenable;
    logic [2:0]            avl_burstcount;
    logic                  avl_waitrequest;
    logic [DATA_W-1:0]     avl_readdata;
    logic                  avl_readdatavalid;

    modport master (
        input  avl_ready, avl_waitrequest, avl_readdata, avl_readdatavalid,
        output avl_address, avl_read, avl_write, avl_writedata,
        output avl_byteenable, avl_burstcount
    );

    modport slave (
        output avl_ready, avl_waitrequest, avl_readdata, avl_readdatavalid,
        input  avl_address, avl_read, avl_write, avl_writedata,
        input  avl_byteenable, avl_burstcount
    );
endinterface

// File: rtl/lpddr2_bridge_req_edge_detect.sv
// Rising-edge detector for one level-held CPU request; the edge is the live
// level against the value registered on the previous clock.
module req_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic rise
);
    logic req_prev_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_prev_reg <= 1'b0;
        end else begin
            req_prev_reg <= req;
        end
    end

    assign rise = req & ~req_prev_reg;
endmodule

// File: rtl/lpddr2_bridge.sv
// Turns level-held CPU read/write requests into single-beat Avalon-MM
// transactions, absorbing waitrequest stalls and readdatavalid latency.
module lpddr2_bridge
    import mem_pkg::*;
#(
    parameter int          ADDR_W   = mem_pkg::LPDDR2_ADDR_W,
    parameter int          DATA_W   = mem_pkg::LPDDR2_DATA_W,
    parameter int          TIMEOUT  = 1023,
    parameter logic [31:0] ERR_WORD = mem_pkg::ERR_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_req,
    input  logic              write_req,
    output logic [DATA_W-1:0] read_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    lpddr2_bridge_if.master   avl
);
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    // Index 0 is the read request, index 1 the write request.
    logic [1:0] req_vec;
    logic [1:0] rise_vec;

    assign req_vec = {write_req, read_req};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_edge
            req_edge_detect u_edge (
                .clk  (clk),
                .rst  (rst),
                .req  (req_vec[gi]),
                .rise (rise_vec[gi])
            );
        end
    endgenerate

    bridge_state_t      state_reg;
    logic               rd_pend_reg;
    logic               wr_pend_reg;
    logic [CNT_W-1:0]   tmo_cnt_reg;
    logic [DATA_W-1:0]  read_data_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               err_reg;
    logic               avl_read_reg;
    logic               avl_write_reg;
    logic [ADDR_W-1:0]  avl_address_reg;
    logic [DATA_W-1:0]  avl_writedata_reg;

    logic rd_go;
    logic wr_go;
    logic tmo_hit;

    // Edges seen while waiting for calibration are replayed on entry to IDLE.
    assign rd_go   = rise_vec[0] | rd_pend_reg;
    assign wr_go   = rise_vec[1] | wr_pend_reg;
    assign tmo_hit = (tmo_cnt_reg == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= INIT;
            rd_pend_reg       <= 1'b0;
            wr_pend_reg       <= 1'b0;
            tmo_cnt_reg       <= '0;
            read_data_reg     <= '0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
            err_reg           <= 1'b0;
            avl_read_reg      <= 1'b0;
            avl_write_reg     <= 1'b0;
            avl_address_reg   <= '0;
            avl_writedata_reg <= '0;
        end else begin
            done_reg    <= 1'b0;
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            case (state_reg)
                INIT: begin
                    tmo_cnt_reg <= '0;
                    if (rise_vec[0]) rd_pend_reg <= 1'b1;
                    if (rise_vec[1]) wr_pend_reg <= 1'b1;
                    if (avl.avl_ready) state_reg <= IDLE;
                end
                IDLE: begin
                    tmo_cnt_reg <= '0;
                    rd_pend_reg <= 1'b0;
                    wr_pend_reg <= 1'b0;
                    if (wr_go || rd_go) begin
                        avl_address_reg   <= address;
                        avl_writedata_reg <= write_data;
                        busy_reg          <= 1'b1;
                    end
                    // A simultaneous read is dropped and flagged; the write proceeds.
                    if (wr_go) begin
                        avl_write_reg <= 1'b1;
                        state_reg     <= WR_CMD;
                        if (rd_go) err_reg <= 1'b1;
                    end else if (rd_go) begin
                        avl_read_reg <= 1'b1;
                        state_reg    <= RD_CMD;
                    end
                end
                RD_CMD: begin
                    if (!avl.avl_waitrequest) begin
                        avl_read_reg <= 1'b0;
                        tmo_cnt_reg  <= '0;
                        state_reg    <= RD_WAIT;
                    end else if (tmo_hit) begin
                        avl_read_reg  <= 1'b0;
                        read_data_reg <= ERR_WORD;
                        err_reg       <= 1'b1;
                        done_reg      <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (avl.avl_readdatavalid) begin
                        read_data_reg <= avl.avl_readdata;
                        done_reg      <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end else if (tmo_hit) begin
                        read_data_reg <= ERR_WORD;
                        err_reg       <= 1'b1;
                        done_reg      <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                WR_CMD: begin
                    if (!avl.avl_waitrequest || tmo_hit) begin
                        avl_write_reg <= 1'b0;
                        done_reg      <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                        if (avl.avl_waitrequest) err_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= INIT;
                end
            endcase
        end
    end

    assign read_data          = read_data_reg;
    assign busy               = busy_reg;
    assign done               = done_reg;
    assign err                = err_reg;
    assign avl.avl_read       = avl_read_reg;
    assign avl.avl_write      = avl_write_reg;
    assign avl.avl_address    = avl_address_reg;
    assign avl.avl_writedata  = avl_writedata_reg;
    assign avl.avl_byteenable = '1;
    assign avl.avl_burstcount = 3'd1;
endmodule

// File: tb/tb_lpddr2_bridge.sv
// Scoreboard bench for lpddr2_bridge: a controller model answers the Avalon
// side, a monitor pops expected commands and completions as they appear.
module tb_lpddr2_bridge;
    localparam int          TIMEOUT  = 1023;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic [26:0] address;
    logic [31:0] write_data;
    logic        read_req;
    logic        write_req;
    logic [31:0] read_data;
    logic        busy;
    logic        done;
    logic        err;

    lpddr2_bridge_if #(.ADDR_W(27), .DATA_W(32)) avl ();

    lpddr2_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .write_data (write_data),
        .read_req   (read_req),
        .write_req  (write_req),
        .read_data  (read_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .avl        (avl)
    );

    typedef struct {
        bit          is_wr;
        logic [26:0] addr;
        logic [31:0] data;
        int          hold;
    } cmd_t;

    typedef struct {
        logic [31:0] rd;
        bit          err;
        int          cyc;
    } done_t;

    cmd_t  cmd_q[$];
    done_t done_q[$];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // Controller model configuration, set per transaction by the stimulus.
    int          cfg_wait  = 0;
    int          cfg_lat   = 1;
    logic [31:0] cfg_rdata = '0;
    bit          late_pulse = 0;

    logic [31:0] exp_rd  = '0;
    bit          exp_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Avalon controller model: waitrequest for cfg_wait cycles per command,
    // readdatavalid cfg_lat edges after acceptance (0 = never answers).
    initial begin
        int  wait_left;
        int  rdv_cnt;
        bit  in_cmd;
        bit  acc_pending;
        bit  acc_was_read;
        wait_left = 0; rdv_cnt = 0; in_cmd = 0; acc_pending = 0; acc_was_read = 0;
        avl.avl_waitrequest   = 1'b0;
        avl.avl_readdatavalid = 1'b0;
        avl.avl_readdata      = 32'h0BAD_0BAD;
        forever begin
            @(posedge clk);
            #1;
            if (acc_pending) begin
                if (acc_was_read && cfg_lat > 0) rdv_cnt = cfg_lat;
                acc_pending = 0;
            end
            avl.avl_readdatavalid = 1'b0;
            avl.avl_readdata      = 32'h0BAD_0BAD;
            if (late_pulse) begin
                avl.avl_readdatavalid = 1'b1;
                avl.avl_readdata      = 32'h1111_1111;
                late_pulse = 0;
            end else if (rdv_cnt > 0) begin
                rdv_cnt--;
                if (rdv_cnt == 0) begin
                    avl.avl_readdatavalid = 1'b1;
                    avl.avl_readdata      = cfg_rdata;
                end
            end
            if ((avl.avl_read || avl.avl_write) && !in_cmd) begin
                in_cmd    = 1;
                wait_left = cfg_wait;
            end
            if (!(avl.avl_read || avl.avl_write)) in_cmd = 0;
            if (in_cmd && wait_left > 0) begin
                avl.avl_waitrequest = 1'b1;
                wait_left--;
            end else begin
                avl.avl_waitrequest = 1'b0;
            end
            if (in_cmd && !avl.avl_waitrequest) begin
                acc_pending  = 1;
                acc_was_read = avl.avl_read;
                in_cmd       = 0;
            end
        end
    end

    // Monitor: compares every accepted command and every done pulse.
    initial begin
        int          hold;
        logic [31:0] last_rd;
        logic        rst_prev;
        cmd_t        c;
        done_t       d;
        hold = 0; last_rd = '0; rst_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (avl.avl_read || avl.avl_write) hold++;
            if ((avl.avl_read || avl.avl_write) && !avl.avl_waitrequest) begin
                if (cmd_q.size() == 0) begin
                    check("unexpected_cmd", 64'(avl.avl_address), 64'h0);
                end else begin
                    c = cmd_q.pop_front();
                    check("cmd_is_write",  64'(avl.avl_write), 64'(c.is_wr));
                    check("cmd_is_read",   64'(avl.avl_read), 64'(!c.is_wr));
                    check("cmd_address",   64'(avl.avl_address), 64'(c.addr));
                    if (c.is_wr) check("cmd_writedata", 64'(avl.avl_writedata), 64'(c.data));
                    check("cmd_hold_cycles", 64'(hold), 64'(c.hold));
                    check("cmd_byteenable", 64'(avl.avl_byteenable), 64'hF);
                    check("cmd_burstcount", 64'(avl.avl_burstcount), 64'h1);
                end
                hold = 0;
            end else if (!(avl.avl_read || avl.avl_write)) begin
                hold = 0;
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'h0);
                end else begin
                    d = done_q.pop_front();
                    check("done_read_data", 64'(read_data), 64'(d.rd));
                    check("done_err", 64'(err), 64'(d.err));
                    if (d.cyc >= 0) check("done_cycle", 64'(cyc), 64'(d.cyc));
                end
            end else if (!rst && !rst_prev && read_data !== last_rd) begin
                check("read_data_held", 64'(read_data), 64'(last_rd));
            end
            last_rd  = read_data;
            rst_prev = rst;
        end
    end

    // Raise a request one cycle before edge N and queue what must come out.
    task automatic issue(input bit rd, input bit wr, input logic [26:0] a,
                         input logic [31:0] d, input int w, input int l,
                         input logic [31:0] rdata, input bit push_done, input bit chk_cyc);
        int n;
        int lat;
        cmd_t  c;
        done_t e;
        @(posedge clk);
        #1;
        cfg_wait  = w;
        cfg_lat   = l;
        cfg_rdata = rdata;
        address    = a;
        write_data = d;
        read_req   = rd;
        write_req  = wr;
        n = cyc + 1;
        c.is_wr = wr; c.addr = a; c.data = d; c.hold = w + 1;
        cmd_q.push_back(c);
        if (wr)          lat = w;
        else if (l > 0)  lat = w + l;
        else             lat = w + TIMEOUT;
        if (push_done) begin
            if (wr && rd) exp_err = 1;
            if (!wr) begin
                exp_rd = (l > 0) ? rdata : ERR_WORD;
                if (l == 0) exp_err = 1;
            end
            e.rd = exp_rd; e.err = exp_err; e.cyc = chk_cyc ? (n + 1 + lat) : -1;
            done_q.push_back(e);
        end
    endtask

    // Hold the request until the bridge is idle with nothing outstanding.
    task automatic finish_req(input int bound);
        int k;
        for (k = 0; k < bound; k++) begin
            @(posedge clk);
            #1;
            if (cmd_q.size() == 0 && done_q.size() == 0 && !busy) break;
        end
        check("completed_within_bound", 64'(k < bound), 64'h1);
        read_req  = 1'b0;
        write_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw;
        rst = 1'b1; address = '0; write_data = '0; read_req = 1'b0; write_req = 1'b0;
        avl.avl_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_read_data", 64'(read_data), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        check("rst_avl_read", 64'(avl.avl_read), 64'h0);
        check("rst_avl_write", 64'(avl.avl_write), 64'h0);
        check("rst_avl_address", 64'(avl.avl_address), 64'h0);
        check("rst_avl_writedata", 64'(avl.avl_writedata), 64'h0);
        check("rst_byteenable", 64'(avl.avl_byteenable), 64'hF);
        check("rst_burstcount", 64'(avl.avl_burstcount), 64'h1);
        rst = 1'b0;

        // Read held through calibration: served once, only after avl_ready.
        issue(1, 0, 27'h0000123, 32'h0, 0, 2, 32'h5A5A_0001, 1, 0);
        saw = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            saw |= (avl.avl_read | avl.avl_write);
        end
        check("init_no_strobe", 64'(saw), 64'h0);
        avl.avl_ready = 1'b1;
        finish_req(100);

        // Stalled read; a write edge during the stall must be ignored.
        issue(1, 0, 27'h0000010, 32'h0, 3, 4, 32'h1234_5678, 1, 1);
        repeat (2) @(posedge clk);
        #1;
        write_data = 32'hFFFF_0000;
        write_req  = 1'b1;
        finish_req(100);

        // Unstalled write to the top address.
        issue(0, 1, 27'h7FF_FFFF, 32'hA5A5_A5A5, 0, 0, 32'h0, 1, 1);
        finish_req(100);

        // Read and write edges together: write wins, err set and sticky.
        issue(1, 1, 27'h0000055, 32'h0F0F_0F0F, 0, 3, 32'h9999_9999, 1, 1);
        finish_req(100);

        // Read that never returns data times out with the error word.
        issue(1, 0, 27'h0000200, 32'h0, 0, 0, 32'h0, 1, 1);
        finish_req(TIMEOUT + 100);
        late_pulse = 1;
        repeat (4) @(posedge clk);
        #1;
        check("late_rdv_ignored", 64'(read_data), 64'(ERR_WORD));
        check("late_rdv_idle", 64'(busy), 64'h0);

        // Reset while waiting for read data; the late response is discarded.
        issue(1, 0, 27'h0001234, 32'h0, 0, 5, 32'h7777_7777, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rd_wait_busy", 64'(busy), 64'h1);
        check("rd_wait_strobe_low", 64'(avl.avl_read), 64'h0);
        rst = 1'b1;
        read_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'h0);
        check("midrst_avl_read", 64'(avl.avl_read), 64'h0);
        check("midrst_err", 64'(err), 64'h0);
        check("midrst_read_data", 64'(read_data), 64'h0);
        exp_rd  = '0;
        exp_err = 0;
        repeat (8) @(posedge clk);
        #1;

        // Normal traffic after reset: stalled read, then stalled write.
        issue(1, 0, 27'h0AB_CDEF, 32'h0, 1, 2, 32'hCAFE_F00D, 1, 1);
        finish_req(100);
        issue(0, 1, 27'h0000001, 32'h0102_0304, 2, 0, 32'h0, 1, 1);
        finish_req(100);

        check("queues_drained", 64'(cmd_q.size() + done_q.size()), 64'h0);
        check("final_err", 64'(err), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
